// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_NREAD = 2;

  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned RF_AW = rf_aw(RF_NREGS);

  typedef logic [RF_AW-1:0] rf_sel_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bundle between decode-writeback logic and the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NREAD = RF_NREAD,
  parameter int unsigned AW    = rf_aw(NREGS)
);

  logic [NREAD*AW-1:0]    rd_sel;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_sel;
  logic [WIDTH-1:0]       wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_sel;
  logic [NREGS-1:0]       busy;
  logic                   err;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    input  rd_data, rd_busy, busy, err
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    output rd_data, rd_busy, busy, err
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: select mux, x0 forcing, write bypass and busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = RF_WIDTH,
  parameter  int unsigned NREGS  = RF_NREGS,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = rf_aw(NREGS)
) (
  input  logic [AW-1:0]          i_sel,
  input  logic [NREGS*WIDTH-1:0] i_regs,
  input  logic [NREGS-1:0]       i_busy,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_sel,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_busy
);

  localparam bit BypassEn = (BYPASS != 0);

  logic [WIDTH-1:0] w_regs [NREGS];
  logic             w_bypass;

  for (genvar g = 0; g < NREGS; g++) begin : g_view
    assign w_regs[g] = i_regs[g*WIDTH +: WIDTH];
  end

  assign w_bypass = BypassEn && i_wr_en && (i_wr_sel == i_sel) && (i_sel != '0);

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_sel != '0) begin
      o_data = w_bypass ? i_wr_data : w_regs[i_sel];
      // A write landing this cycle satisfies the pending producer.
      o_busy = i_busy[i_sel] && !w_bypass;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass and per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = RF_WIDTH,
  parameter  int unsigned NREGS  = RF_NREGS,
  parameter  int unsigned NREAD  = RF_NREAD,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = rf_aw(NREGS)
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  logic [NREGS*WIDTH-1:0] w_rf_flat;
  logic [NREGS-1:0]       w_busy;
  logic                   w_dbl_rsv;
  logic                   r_err;

  // x0 has no storage and can never be busy.
  assign w_rf_flat[WIDTH-1:0] = '0;
  assign w_busy[0]            = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             w_wr_hit;
    logic             w_rsv_hit;

    assign w_wr_hit  = bus.wr_en  && (bus.wr_sel  == AW'(g));
    assign w_rsv_hit = bus.rsv_en && (bus.rsv_sel == AW'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
        r_busy <= 1'b0;
      end else begin
        if (w_wr_hit) begin
          r_data <= bus.wr_data;
        end
        // A new reservation outranks a completing write: the new producer owns the register.
        if (w_rsv_hit) begin
          r_busy <= 1'b1;
        end else if (w_wr_hit) begin
          r_busy <= 1'b0;
        end
      end
    end

    assign w_rf_flat[g*WIDTH +: WIDTH] = r_data;
    assign w_busy[g]                   = r_busy;
  end

  assign w_dbl_rsv = bus.rsv_en && (bus.rsv_sel != '0) && w_busy[bus.rsv_sel] &&
                     !(bus.wr_en && (bus.wr_sel == bus.rsv_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_dbl_rsv) begin
      r_err <= 1'b1;
    end
  end

  assign bus.busy = w_busy;
  assign bus.err  = r_err;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_read_port #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_sel     (bus.rd_sel[p*AW +: AW]),
      .i_regs    (w_rf_flat),
      .i_busy    (w_busy),
      .i_wr_en   (bus.wr_en),
      .i_wr_sel  (bus.wr_sel),
      .i_wr_data (bus.wr_data),
      .o_data    (bus.rd_data[p*WIDTH +: WIDTH]),
      .o_busy    (bus.rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a 3-port bypassing instance plus a 1-port non-bypassing instance.
module tb_regfile_mp;

  localparam int KData   = 0;
  localparam int KRBusy  = 1;
  localparam int KBusy   = 2;
  localparam int KErr    = 3;
  localparam int KNbData = 4;
  localparam int KNbBusy = 5;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } chk_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  chk_t q[$];

  regfile_mp_if #(.NREAD(3)) bus ();
  regfile_mp_if #(.NREAD(1)) bus_nb ();

  regfile_mp #(.NREAD(3), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_mp #(.NREAD(1), .BYPASS(0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  assign bus_nb.rd_sel  = bus.rd_sel[4:0];
  assign bus_nb.wr_en   = bus.wr_en;
  assign bus_nb.wr_sel  = bus.wr_sel;
  assign bus_nb.wr_data = bus.wr_data;
  assign bus_nb.rsv_en  = bus.rsv_en;
  assign bus_nb.rsv_sel = bus.rsv_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input int k, input int p, input logic [31:0] x);
    chk_t e;
    e.name = n;
    e.kind = k;
    e.port = p;
    e.exp  = x;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bus.rd_sel = {c, b, a};
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.rsv_en  = 1'b0;
    bus.rsv_sel = '0;
  endtask

  // Monitor: outputs are stable mid-cycle, so drain everything queued for this cycle.
  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        KData:   act = bus.rd_data[e.port*32 +: 32];
        KRBusy:  act = {31'b0, bus.rd_busy[e.port]};
        KBusy:   act = bus.busy;
        KErr:    act = {31'b0, bus.err};
        KNbData: act = bus_nb.rd_data;
        default: act = {31'b0, bus_nb.rd_busy[0]};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s port%0d: got %h want %h", e.name, e.port, act, e.exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    sel3(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      sel3(5'(i), 5'(i), 5'(i));
      for (int p = 0; p < 3; p++) begin
        push("reset_data", KData, p, 32'h0);
        push("reset_rbusy", KRBusy, p, 32'h0);
      end
      push("reset_busy", KBusy, 0, 32'h0);
      push("reset_err", KErr, 0, 32'h0);
      step();
    end

    bus.wr_en = 1'b1; bus.wr_sel = 5'd0; bus.wr_data = 32'hDEADBEEF;
    sel3(0, 0, 0);
    push("x0_bypass", KData, 0, 32'h0);
    push("x0_nb", KNbData, 0, 32'h0);
    step();
    idle();
    push("x0_after", KData, 0, 32'h0);
    push("x0_busy", KBusy, 0, 32'h0);
    push("x0_err", KErr, 0, 32'h0);
    step();

    bus.wr_en = 1'b1; bus.wr_sel = 5'd5; bus.wr_data = 32'h12345678;
    sel3(5, 0, 0);
    push("x5_bypass", KData, 0, 32'h12345678);
    push("x5_nb_old", KNbData, 0, 32'h0);
    push("x5_p1_x0", KData, 1, 32'h0);
    step();
    idle();
    push("x5_stored", KData, 0, 32'h12345678);
    push("x5_nb_new", KNbData, 0, 32'h12345678);
    step();

    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd7;
    sel3(7, 7, 0);
    push("rsv7_same", KRBusy, 0, 32'h0);
    step();
    idle();
    push("rsv7_rb0", KRBusy, 0, 32'h1);
    push("rsv7_rb1", KRBusy, 1, 32'h1);
    push("rsv7_busy", KBusy, 0, 32'h80);
    push("rsv7_nb_rb", KNbBusy, 0, 32'h1);
    step();

    bus.wr_en = 1'b1; bus.wr_sel = 5'd7; bus.wr_data = 32'hA5A5A5A5;
    push("wr7_rbusy", KRBusy, 0, 32'h0);
    push("wr7_data", KData, 0, 32'hA5A5A5A5);
    push("wr7_nb_rb", KNbBusy, 0, 32'h1);
    push("wr7_nb_data", KNbData, 0, 32'h0);
    push("wr7_busy_same", KBusy, 0, 32'h80);
    step();
    idle();
    push("wr7_busy_next", KBusy, 0, 32'h0);
    push("wr7_rb_next", KRBusy, 0, 32'h0);
    push("wr7_nb_rb_next", KNbBusy, 0, 32'h0);
    push("wr7_stored", KData, 0, 32'hA5A5A5A5);
    step();

    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd9;
    bus.wr_en  = 1'b1; bus.wr_sel = 5'd9; bus.wr_data = 32'h1;
    sel3(9, 0, 0);
    push("rw9_rb_same", KRBusy, 0, 32'h0);
    step();
    idle();
    push("rw9_data", KData, 0, 32'h1);
    push("rw9_busy", KBusy, 0, 32'h200);
    push("rw9_rbusy", KRBusy, 0, 32'h1);
    push("rw9_err", KErr, 0, 32'h0);
    step();

    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd9;
    push("dbl_err_same", KErr, 0, 32'h0);
    step();
    idle();
    push("dbl_err_set", KErr, 0, 32'h1);
    step();
    push("dbl_err_hold", KErr, 0, 32'h1);
    step();

    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd10;
    bus.wr_en  = 1'b1; bus.wr_sel = 5'd11; bus.wr_data = 32'h77;
    sel3(11, 10, 0);
    push("indep_bypass", KData, 0, 32'h77);
    step();
    idle();
    push("indep_busy", KBusy, 0, 32'h600);
    push("indep_data", KData, 0, 32'h77);
    push("indep_rb10", KRBusy, 1, 32'h1);
    push("indep_err", KErr, 0, 32'h1);
    step();
    bus.wr_en = 1'b1; bus.wr_sel = 5'd10; bus.wr_data = 32'h55;
    step();
    idle();
    push("clr10_busy", KBusy, 0, 32'h200);
    push("clr10_data", KData, 1, 32'h55);
    step();

    bus.wr_en = 1'b1; bus.wr_sel = 5'd3; bus.wr_data = 32'h0000CAFE;
    step();
    idle();
    sel3(3, 3, 3);
    for (int p = 0; p < 3; p++) begin
      push("mp_x3", KData, p, 32'h0000CAFE);
    end
    step();
    sel3(3, 5, 0);
    push("mp_mix0", KData, 0, 32'h0000CAFE);
    push("mp_mix1", KData, 1, 32'h12345678);
    push("mp_mix2", KData, 2, 32'h0);
    step();

    rst = 1'b1;
    bus.wr_en  = 1'b1; bus.wr_sel = 5'd3; bus.wr_data = 32'h1111;
    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd4;
    step();
    rst = 1'b0;
    idle();
    sel3(3, 4, 9);
    push("rst_x3", KData, 0, 32'h0);
    push("rst_rb4", KRBusy, 1, 32'h0);
    push("rst_x9", KData, 2, 32'h0);
    push("rst_busy", KBusy, 0, 32'h0);
    push("rst_err", KErr, 0, 32'h0);
    push("rst_nb_x3", KNbData, 0, 32'h0);
    step();

    bus.rsv_en = 1'b1; bus.rsv_sel = 5'd4;
    step();
    idle();
    push("post_rst_busy", KBusy, 0, 32'h10);
    push("post_rst_err", KErr, 0, 32'h0);
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
